// File: rtl/axil_sram_slave.sv
// AXI4-Lite slave fronting a word-addressed SRAM window,
// with SLVERR outside the window and a sticky pass flag.
module axil_sram_slave #(
  parameter logic [31:0] BASE_ADDR = 32'h0010_0000,
  parameter int unsigned DEPTH     = 32768,
  parameter logic [31:0] PASS_ADDR = 32'h2000_0000,
  parameter logic [31:0] PASS_DATA = 32'd123456789
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        s_aw_valid,
  output logic        s_aw_ready,
  input  logic [31:0] s_aw_addr,
  input  logic [2:0]  s_aw_prot,
  input  logic        s_w_valid,
  output logic        s_w_ready,
  input  logic [31:0] s_w_data,
  input  logic [3:0]  s_w_strb,
  output logic        s_b_valid,
  input  logic        s_b_ready,
  output logic [1:0]  s_b_resp,
  input  logic        s_ar_valid,
  output logic        s_ar_ready,
  input  logic [31:0] s_ar_addr,
  output logic        s_r_valid,
  input  logic        s_r_ready,
  output logic [31:0] s_r_data,
  output logic [1:0]  s_r_resp,
  output logic        tests_passed
);

  localparam int AW = $clog2(DEPTH);
  localparam logic [32:0] END_ADDR =
    {1'b0, BASE_ADDR} + (33'(DEPTH) << 2);
  localparam logic [1:0] OKAY   = 2'b00;
  localparam logic [1:0] SLVERR = 2'b10;

  logic [31:0] mem [DEPTH];

  logic          w_acc;
  logic          r_acc;
  logic          w_hit;
  logic          r_hit;
  logic          w_pass;
  logic [31:0]   w_off;
  logic [31:0]   r_off;
  logic [AW-1:0] w_idx;
  logic [AW-1:0] r_idx;
  logic          unused;

  // 33-bit compare so the top of the window never wraps
  function automatic logic in_win(input logic [31:0] a);
    return ({1'b0, a} >= {1'b0, BASE_ADDR}) &&
           ({1'b0, a} < END_ADDR);
  endfunction

  assign w_hit  = in_win(s_aw_addr);
  assign r_hit  = in_win(s_ar_addr);
  assign w_pass = (s_aw_addr == PASS_ADDR);
  assign w_off  = s_aw_addr - BASE_ADDR;
  assign r_off  = s_ar_addr - BASE_ADDR;
  assign w_idx  = w_off[AW+1:2];
  assign r_idx  = r_off[AW+1:2];

  assign unused = ^{s_aw_prot,
                    w_off[31:AW+2], w_off[1:0],
                    r_off[31:AW+2], r_off[1:0]};

  assign s_aw_ready = rst_n & s_aw_valid
                    & s_w_valid & ~s_b_valid;
  assign s_w_ready  = s_aw_ready;
  assign w_acc      = s_aw_ready;

  assign s_ar_ready = rst_n & ~s_r_valid;
  assign r_acc      = s_ar_valid & s_ar_ready;

  always_ff @(posedge clk) begin
    if (w_acc && w_hit) begin
      for (int i = 0; i < 4; i++) begin
        if (s_w_strb[i]) begin
          mem[w_idx][8*i +: 8] <= s_w_data[8*i +: 8];
        end
      end
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      s_b_valid    <= 1'b0;
      s_b_resp     <= OKAY;
      tests_passed <= 1'b0;
    end else begin
      if (w_acc) begin
        s_b_valid <= 1'b1;
        unique case (1'b1)
          w_hit:   s_b_resp <= OKAY;
          w_pass:  s_b_resp <= OKAY;
          default: s_b_resp <= SLVERR;
        endcase
      end else if (s_b_valid && s_b_ready) begin
        s_b_valid <= 1'b0;
      end
      if (w_acc && w_pass && s_w_data == PASS_DATA) begin
        tests_passed <= 1'b1;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      s_r_valid <= 1'b0;
      s_r_data  <= '0;
      s_r_resp  <= OKAY;
    end else begin
      if (r_acc) begin
        s_r_valid <= 1'b1;
        unique case (1'b1)
          r_hit: begin
            s_r_data <= mem[r_idx];
            s_r_resp <= OKAY;
          end
          default: begin
            s_r_data <= '0;
            s_r_resp <= SLVERR;
          end
        endcase
      end else if (s_r_valid && s_r_ready) begin
        s_r_valid <= 1'b0;
      end
    end
  end

endmodule

// File: tb/tb_axil_sram_slave.sv
// Bench for axil_sram_slave: directed AXI-Lite traffic,
// a transaction-level model checked every negedge.
module tb_axil_sram_slave;

  localparam logic [31:0] BASE  = 32'h0010_0000;
  localparam int          DEPTH = 32768;
  localparam logic [31:0] PADDR = 32'h2000_0000;
  localparam logic [31:0] PDATA = 32'd123456789;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        s_aw_valid = 1'b0;
  logic        s_aw_ready;
  logic [31:0] s_aw_addr = '0;
  logic [2:0]  s_aw_prot = '0;
  logic        s_w_valid = 1'b0;
  logic        s_w_ready;
  logic [31:0] s_w_data = '0;
  logic [3:0]  s_w_strb = '0;
  logic        s_b_valid;
  logic        s_b_ready = 1'b1;
  logic [1:0]  s_b_resp;
  logic        s_ar_valid = 1'b0;
  logic        s_ar_ready;
  logic [31:0] s_ar_addr = '0;
  logic        s_r_valid;
  logic        s_r_ready = 1'b1;
  logic [31:0] s_r_data;
  logic [1:0]  s_r_resp;
  logic        tests_passed;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  axil_sram_slave dut (
    .clk(clk), .rst_n(rst_n),
    .s_aw_valid(s_aw_valid), .s_aw_ready(s_aw_ready),
    .s_aw_addr(s_aw_addr), .s_aw_prot(s_aw_prot),
    .s_w_valid(s_w_valid), .s_w_ready(s_w_ready),
    .s_w_data(s_w_data), .s_w_strb(s_w_strb),
    .s_b_valid(s_b_valid), .s_b_ready(s_b_ready),
    .s_b_resp(s_b_resp),
    .s_ar_valid(s_ar_valid), .s_ar_ready(s_ar_ready),
    .s_ar_addr(s_ar_addr),
    .s_r_valid(s_r_valid), .s_r_ready(s_r_ready),
    .s_r_data(s_r_data), .s_r_resp(s_r_resp),
    .tests_passed(tests_passed)
  );

  task automatic chk(input string nm,
                     input logic [31:0] act,
                     input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%h required=%h",
               nm, act, exp);
    end
  endtask

  // transaction-level model of the slave
  logic [31:0] mm [DEPTH];
  logic        armed = 1'b0;
  logic        m_bv, m_rv, m_tp;
  logic [1:0]  m_bresp, m_rresp;
  logic [31:0] m_rdata;

  function automatic bit win(input logic [31:0] a);
    longint x;
    x = longint'(a);
    return x >= longint'(BASE) &&
           x < longint'(BASE) + 4 * DEPTH;
  endfunction

  always @(negedge clk) begin : model
    logic ex_aw, ex_ar;
    int wi, ri;
    ex_aw = rst_n & s_aw_valid & s_w_valid & ~m_bv;
    ex_ar = rst_n & ~m_rv;
    if (armed) begin
      chk("aw_ready", 32'(s_aw_ready), 32'(ex_aw));
      chk("w_ready", 32'(s_w_ready), 32'(ex_aw));
      chk("ar_ready", 32'(s_ar_ready), 32'(ex_ar));
      chk("b_valid", 32'(s_b_valid), 32'(m_bv));
      chk("r_valid", 32'(s_r_valid), 32'(m_rv));
      chk("passed", 32'(tests_passed), 32'(m_tp));
      if (m_bv) chk("b_resp", 32'(s_b_resp), 32'(m_bresp));
      if (m_rv) begin
        chk("r_resp", 32'(s_r_resp), 32'(m_rresp));
        chk("r_data", s_r_data, m_rdata);
      end
    end
    if (!rst_n) begin
      armed = 1'b1;
      m_bv = 0; m_rv = 0; m_tp = 0;
      m_bresp = 0; m_rresp = 0; m_rdata = 0;
    end else if (armed) begin
      if (ex_ar && s_ar_valid) begin
        m_rv = 1;
        if (win(s_ar_addr)) begin
          ri = int'((s_ar_addr - BASE) >> 2);
          m_rdata = mm[ri];
          m_rresp = 2'b00;
        end else begin
          m_rdata = 0;
          m_rresp = 2'b10;
        end
      end else if (m_rv && s_r_ready) begin
        m_rv = 0;
      end
      if (ex_aw) begin
        m_bv = 1;
        if (win(s_aw_addr)) begin
          wi = int'((s_aw_addr - BASE) >> 2);
          for (int i = 0; i < 4; i++)
            if (s_w_strb[i])
              mm[wi][8*i +: 8] = s_w_data[8*i +: 8];
          m_bresp = 2'b00;
        end else if (s_aw_addr == PADDR) begin
          m_bresp = 2'b00;
          if (s_w_data == PDATA) m_tp = 1;
        end else begin
          m_bresp = 2'b10;
        end
      end else if (m_bv && s_b_ready) begin
        m_bv = 0;
      end
    end
  end

  // called at posedge+1; returns at posedge+1 after B done
  task automatic wr(input logic [31:0] a, d,
                    input logic [3:0] st,
                    output logic [1:0] rs);
    int n;
    n = 0;
    s_aw_addr = a; s_w_data = d; s_w_strb = st;
    s_aw_valid = 1; s_w_valid = 1;
    do begin
      @(negedge clk); n++;
    end while (!s_aw_ready && n < 20);
    chk("aw_accept", 32'(s_aw_ready), 32'd1);
    @(posedge clk); #1;
    s_aw_valid = 0; s_w_valid = 0;
    chk("b_lat", 32'(s_b_valid), 32'd1);
    rs = s_b_resp;
    @(posedge clk); #1;
  endtask

  task automatic rd(input logic [31:0] a,
                    output logic [31:0] d,
                    output logic [1:0] rs);
    int n;
    n = 0;
    s_ar_addr = a; s_ar_valid = 1;
    do begin
      @(negedge clk); n++;
    end while (!s_ar_ready && n < 20);
    chk("ar_accept", 32'(s_ar_ready), 32'd1);
    @(posedge clk); #1;
    s_ar_valid = 0;
    chk("r_lat", 32'(s_r_valid), 32'd1);
    d = s_r_data; rs = s_r_resp;
    @(posedge clk); #1;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog expired");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [1:0]  rs;
    logic [31:0] d;
    repeat (2) @(posedge clk);
    #1;
    chk("rst_b_valid", 32'(s_b_valid), 32'd0);
    chk("rst_r_valid", 32'(s_r_valid), 32'd0);
    chk("rst_b_resp", 32'(s_b_resp), 32'd0);
    chk("rst_r_resp", 32'(s_r_resp), 32'd0);
    chk("rst_r_data", s_r_data, 32'd0);
    chk("rst_passed", 32'(tests_passed), 32'd0);
    rst_n = 1;
    @(posedge clk); #1;

    wr(BASE, 32'hA5A5_1234, 4'hF, rs);
    chk("t1_bresp", 32'(rs), 32'd0);
    rd(BASE, d, rs);
    chk("t1_rdata", d, 32'hA5A5_1234);
    chk("t1_rresp", 32'(rs), 32'd0);

    wr(BASE + 4, 32'hFFFF_FFFF, 4'hF, rs);
    wr(BASE + 4, 32'h0000_0000, 4'b0101, rs);
    rd(BASE + 4, d, rs);
    chk("t2_rdata", d, 32'hFF00_FF00);

    s_aw_addr = BASE + 8; s_aw_valid = 1;
    repeat (5) begin
      @(negedge clk);
      chk("t3_aw_hold", 32'(s_aw_ready), 32'd0);
      chk("t3_w_hold", 32'(s_w_ready), 32'd0);
    end
    @(posedge clk); #1;
    s_w_data = 32'h1357_9BDF; s_w_strb = 4'hF;
    s_w_valid = 1;
    @(negedge clk);
    chk("t3_aw_rdy", 32'(s_aw_ready), 32'd1);
    chk("t3_w_rdy", 32'(s_w_ready), 32'd1);
    @(posedge clk); #1;
    s_aw_valid = 0; s_w_valid = 0;
    @(posedge clk); #1;
    rd(BASE + 8, d, rs);
    chk("t3_rdata", d, 32'h1357_9BDF);

    s_b_ready = 0;
    s_aw_addr = BASE + 12; s_w_data = 32'h1111_1111;
    s_aw_valid = 1; s_w_valid = 1;
    @(posedge clk); #1;
    s_aw_addr = BASE + 16; s_w_data = 32'h2222_2222;
    repeat (4) begin
      @(negedge clk);
      chk("t4_bv_hold", 32'(s_b_valid), 32'd1);
      chk("t4_bresp", 32'(s_b_resp), 32'd0);
      chk("t4_aw_block", 32'(s_aw_ready), 32'd0);
    end
    @(posedge clk); #1;
    s_b_ready = 1;
    @(negedge clk);
    chk("t4_aw_block2", 32'(s_aw_ready), 32'd0);
    @(negedge clk);
    chk("t4_aw_next", 32'(s_aw_ready), 32'd1);
    @(posedge clk); #1;
    s_aw_valid = 0; s_w_valid = 0;
    @(posedge clk); #1;

    s_r_ready = 0;
    s_ar_addr = BASE + 12; s_ar_valid = 1;
    @(posedge clk); #1;
    s_ar_addr = BASE + 16;
    repeat (4) begin
      @(negedge clk);
      chk("t4_rv_hold", 32'(s_r_valid), 32'd1);
      chk("t4_rdata", s_r_data, 32'h1111_1111);
      chk("t4_ar_block", 32'(s_ar_ready), 32'd0);
    end
    @(posedge clk); #1;
    s_r_ready = 1;
    @(negedge clk);
    @(negedge clk);
    chk("t4_ar_next", 32'(s_ar_ready), 32'd1);
    @(posedge clk); #1;
    s_ar_valid = 0;
    chk("t4_rdata2", s_r_data, 32'h2222_2222);
    @(posedge clk); #1;

    rd(32'h0020_0000, d, rs);
    chk("t5_far_resp", 32'(rs), 32'd2);
    chk("t5_far_data", d, 32'd0);
    rd(32'h0012_0000, d, rs);
    chk("t5_end_resp", 32'(rs), 32'd2);
    wr(32'h0011_FFFC, 32'hCAFE_F00D, 4'hF, rs);
    chk("t5_top_wresp", 32'(rs), 32'd0);
    wr(32'h000F_FFFC, 32'hDEAD_BEEF, 4'hF, rs);
    chk("t5_low_wresp", 32'(rs), 32'd2);
    rd(32'h0011_FFFC, d, rs);
    chk("t5_top_data", d, 32'hCAFE_F00D);
    chk("t5_top_rresp", 32'(rs), 32'd0);
    rd(BASE, d, rs);
    chk("t5_w0_kept", d, 32'hA5A5_1234);

    s_aw_addr = BASE; s_w_data = 32'h0BAD_0BAD;
    s_w_strb = 4'hF; s_ar_addr = BASE;
    s_aw_valid = 1; s_w_valid = 1; s_ar_valid = 1;
    @(negedge clk);
    chk("rw_aw_rdy", 32'(s_aw_ready), 32'd1);
    chk("rw_ar_rdy", 32'(s_ar_ready), 32'd1);
    @(posedge clk); #1;
    s_aw_valid = 0; s_w_valid = 0; s_ar_valid = 0;
    chk("rw_old_data", s_r_data, 32'hA5A5_1234);
    @(posedge clk); #1;
    rd(BASE, d, rs);
    chk("rw_new_data", d, 32'h0BAD_0BAD);

    wr(PADDR, 32'd42, 4'hF, rs);
    chk("t6_bad_resp", 32'(rs), 32'd0);
    chk("t6_bad_flag", 32'(tests_passed), 32'd0);
    wr(32'h3000_0000, PDATA, 4'hF, rs);
    chk("t6_other_resp", 32'(rs), 32'd2);
    chk("t6_other_flag", 32'(tests_passed), 32'd0);
    wr(PADDR, PDATA, 4'hF, rs);
    chk("t6_pass_resp", 32'(rs), 32'd0);
    chk("t6_pass_flag", 32'(tests_passed), 32'd1);
    repeat (3) @(posedge clk);
    #1;
    chk("t6_sticky", 32'(tests_passed), 32'd1);

    s_b_ready = 0; s_r_ready = 0;
    s_aw_addr = BASE + 20; s_w_data = 32'h5555_5555;
    s_ar_addr = BASE + 4;
    s_aw_valid = 1; s_w_valid = 1; s_ar_valid = 1;
    @(posedge clk); #1;
    s_ar_valid = 0;
    s_aw_addr = BASE; s_w_data = 32'h7777_7777;
    rst_n = 0;
    @(negedge clk);
    chk("rst_aw_rdy", 32'(s_aw_ready), 32'd0);
    chk("rst_ar_rdy", 32'(s_ar_ready), 32'd0);
    @(posedge clk); #1;
    chk("rst2_b_valid", 32'(s_b_valid), 32'd0);
    chk("rst2_r_valid", 32'(s_r_valid), 32'd0);
    chk("rst2_passed", 32'(tests_passed), 32'd0);
    s_aw_valid = 0; s_w_valid = 0;
    s_b_ready = 1; s_r_ready = 1;
    rst_n = 1;
    @(posedge clk); #1;
    rd(BASE, d, rs);
    chk("rst_no_write", d, 32'h0BAD_0BAD);
    rd(BASE + 20, d, rs);
    chk("pre_rst_write", d, 32'h5555_5555);

    repeat (3) @(posedge clk);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
